// File: rtl/barrido_tabla_verdad.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | barrido_tabla_verdad                                                     |
// | Exhaustive truth-table sweeper: drives every input vector to a small     |
// | combinational DUT, captures each response and folds it into a MISR.      |
// | Optional: BARRIDO_GRAY_EN selects Gray-ordered vectors.                  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module barrido_tabla_verdad #(
  parameter int               N_IN  = 3,
  parameter int               N_OUT = 2,
  parameter int               HOLD  = 1,
  parameter int               SIG_W = 8,
  parameter logic [SIG_W-1:0] POLY  = 8'h1D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  dut_in,
  input  logic [N_OUT-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             sample_valid,
  output logic [N_IN-1:0]  sample_idx,
  output logic [N_IN-1:0]  sample_vec,
  output logic [N_OUT-1:0] sample_data,
  output logic [SIG_W-1:0] signature
);

  localparam int              CNT_W    = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
  localparam logic [CNT_W-1:0] C_HOLD   = CNT_W'(HOLD);
  localparam logic [N_IN:0]   C_LAST   = (N_IN + 1)'((1 << N_IN) - 1);
  localparam logic [N_IN:0]   C_ONE    = (N_IN + 1)'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [N_IN:0]     r_idx;
  logic [N_IN:0]     w_idx_inc;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_launch;
  logic              w_abort;
  logic              w_capture;
  logic              w_last;
  logic              w_count;
  logic [SIG_W-1:0]  w_sig_next;

  function automatic logic [N_IN-1:0] vec_of(input logic [N_IN-1:0] k);
`ifdef BARRIDO_GRAY_EN
    return k ^ (k >> 1);
`else
    return k;
`endif
  endfunction

  assign w_idx_inc  = r_idx + C_ONE;
  assign w_sig_next = ({signature[SIG_W-2:0], 1'b0} ^ (signature[SIG_W-1] ? POLY : '0))
                      ^ SIG_W'(dut_out);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // abort outranks a capture that falls on the same edge
  always_comb begin
    w_next    = r_state;
    w_launch  = 1'b0;
    w_abort   = 1'b0;
    w_capture = 1'b0;
    w_last    = 1'b0;
    w_count   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_next   = S_SWEEP;
          w_launch = 1'b1;
        end
      end
      S_SWEEP: begin
        if (abort) begin
          w_next  = S_IDLE;
          w_abort = 1'b1;
        end else if (r_cnt == C_HOLD) begin
          w_capture = 1'b1;
          if (r_idx == C_LAST) begin
            w_last = 1'b1;
            w_next = S_IDLE;
          end
        end else begin
          w_count = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= '0;
      r_cnt        <= '0;
      dut_in       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sample_valid <= 1'b0;
      sample_idx   <= '0;
      sample_vec   <= '0;
      sample_data  <= '0;
      signature    <= '0;
    end else begin
      sample_valid <= 1'b0;
      done         <= 1'b0;
      if (w_launch) begin
        busy      <= 1'b1;
        r_idx     <= '0;
        r_cnt     <= '0;
        signature <= '0;
        dut_in    <= vec_of('0);
      end
      if (w_abort) begin
        busy   <= 1'b0;
        dut_in <= '0;
        r_cnt  <= '0;
      end
      if (w_count) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_capture) begin
        sample_valid <= 1'b1;
        sample_idx   <= r_idx[N_IN-1:0];
        sample_vec   <= dut_in;
        sample_data  <= dut_out;
        signature    <= w_sig_next;
        r_cnt        <= '0;
        r_idx        <= w_idx_inc;
        if (w_last) begin
          busy   <= 1'b0;
          done   <= 1'b1;
          dut_in <= '0;
        end else begin
          dut_in <= vec_of(w_idx_inc[N_IN-1:0]);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_barrido_tabla_verdad.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_barrido_tabla_verdad                                                  |
// | Directed bench: HOLD=1 and HOLD=0 sweepers on a parity/majority DUT.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_barrido_tabla_verdad;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start0 = 1'b0;
  logic       abort0 = 1'b0;
  logic       start1 = 1'b0;
  logic [2:0] dut_in0, dut_in1, sample_idx0, sample_vec0, sample_idx1, sample_vec1;
  logic [1:0] dut_out0, dut_out1, sample_data0, sample_data1;
  logic       busy0, done0, sv0, busy1, done1, sv1;
  logic [7:0] sig0, sig1;

  int n_checks = 0;
  int n_errors = 0;
  int ns0 = 0, ns1 = 0, nd0 = 0, nd1 = 0;
  logic [2:0] s_idx [256];
  logic [2:0] s_vec [256];
  logic [1:0] s_dat [256];
  logic [1:0] s_dat1 [256];

`ifdef BARRIDO_GRAY_EN
  logic [2:0] exp_vec [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
  logic [1:0] exp_dat [8] = '{2'd0, 2'd2, 2'd1, 2'd2, 2'd1, 2'd3, 2'd1, 2'd2};
  logic [7:0] exp_sig  = 8'h84;
  logic [7:0] exp_part = 8'h05;
`else
  logic [2:0] exp_vec [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [1:0] exp_dat [8] = '{2'd0, 2'd2, 2'd2, 2'd1, 2'd2, 2'd1, 2'd1, 2'd3};
  logic [7:0] exp_sig  = 8'hC5;
  logic [7:0] exp_part = 8'h06;
`endif

  // parity in bit 1, majority in bit 0
  assign dut_out0 = {^dut_in0, (dut_in0[0] & dut_in0[1]) | (dut_in0[0] & dut_in0[2]) | (dut_in0[1] & dut_in0[2])};
  assign dut_out1 = {^dut_in1, (dut_in1[0] & dut_in1[1]) | (dut_in1[0] & dut_in1[2]) | (dut_in1[1] & dut_in1[2])};

  barrido_tabla_verdad #(.N_IN(3), .N_OUT(2), .HOLD(1), .SIG_W(8), .POLY(8'h1D)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
    .dut_in(dut_in0), .dut_out(dut_out0), .busy(busy0), .done(done0),
    .sample_valid(sv0), .sample_idx(sample_idx0), .sample_vec(sample_vec0),
    .sample_data(sample_data0), .signature(sig0)
  );

  barrido_tabla_verdad #(.N_IN(3), .N_OUT(2), .HOLD(0), .SIG_W(8), .POLY(8'h1D)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0),
    .dut_in(dut_in1), .dut_out(dut_out1), .busy(busy1), .done(done1),
    .sample_valid(sv1), .sample_idx(sample_idx1), .sample_vec(sample_vec1),
    .sample_data(sample_data1), .signature(sig1)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sv0) begin
      s_idx[ns0 % 256] = sample_idx0;
      s_vec[ns0 % 256] = sample_vec0;
      s_dat[ns0 % 256] = sample_data0;
      ns0++;
    end
    if (done0) nd0++;
    if (sv1) begin
      s_dat1[ns1 % 256] = sample_data1;
      ns1++;
    end
    if (done1) nd1++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input bit which, input int limit, output int cyc);
    cyc = 0;
    forever begin
      step();
      cyc++;
      if ((which ? done1 : done0) === 1'b1) break;
      if (cyc >= limit) begin
        cyc = -1;
        break;
      end
    end
  endtask

  task automatic check_sweep(input string tag, input int base);
    for (int i = 0; i < 8; i++) begin
      check_eq({tag, "_idx"}, 32'(s_idx[(base + i) % 256]), i);
      check_eq({tag, "_vec"}, 32'(s_vec[(base + i) % 256]), 32'(exp_vec[i]));
      check_eq({tag, "_dat"}, 32'(s_dat[(base + i) % 256]), 32'(exp_dat[i]));
    end
  endtask

  initial begin
    int base;
    int dbase;
    int cyc;

    // reset state
    repeat (2) step();
    check_eq("rst_out0", {busy0, done0, sv0, dut_in0, sample_idx0, sample_vec0, sample_data0, sig0}, 0);
    check_eq("rst_out1", {busy1, done1, sv1, dut_in1, sample_idx1, sample_vec1, sample_data1, sig1}, 0);
    rst_n = 1'b1;
    step();

    // full sweep, HOLD=1, vector hold and done timing checked per cycle
    base = ns0;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    check_eq("t1_busy", busy0, 1);
    check_eq("t1_vec0", dut_in0, exp_vec[0]);
    for (int e = 1; e < 16; e++) begin
      step();
      check_eq("t1_hold", dut_in0, exp_vec[e >> 1]);
      check_eq("t1_nodone", done0, 0);
    end
    step();
    check_eq("t1_done", done0, 1);
    check_eq("t1_busy_end", busy0, 0);
    check_eq("t1_dutin_end", dut_in0, 0);
    check_eq("t1_last_sv", sv0, 1);
    check_eq("t1_sig", sig0, exp_sig);
    check_eq("t1_nsamp", ns0 - base, 8);
    check_sweep("t1", base);
    step();
    check_eq("t1_done_pulse", done0, 0);
    check_eq("t1_sig_hold", sig0, exp_sig);

    // abort at cycle 7
    base = ns0;
    dbase = nd0;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    repeat (6) step();
    abort0 = 1'b1;
    step();
    abort0 = 1'b0;
    check_eq("t3_busy", busy0, 0);
    check_eq("t3_dutin", dut_in0, 0);
    repeat (20) step();
    check_eq("t3_nsamp", ns0 - base, 3);
    check_eq("t3_nodone", nd0 - dbase, 0);
    check_eq("t3_sig_part", sig0, exp_part);
    check_eq("t3_idle", {busy0, dut_in0}, 0);

    // async reset mid-sweep, then a clean sweep
    dbase = nd0;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    repeat (9) step();
    check_eq("t4_busy_pre", busy0, 1);
    rst_n = 1'b0;
    #1;
    check_eq("t4_rst_out", {busy0, done0, sv0, dut_in0, sample_idx0, sample_vec0, sample_data0, sig0}, 0);
    step();
    rst_n = 1'b1;
    step();
    base = ns0;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    wait_done(1'b0, 40, cyc);
    check_eq("t4_latency", cyc, 16);
    check_eq("t4_sig", sig0, exp_sig);
    check_eq("t4_nsamp", ns0 - base, 8);
    check_eq("t4_one_done", nd0 - dbase, 1);

    // start held high: no restart while busy, re-launch right after done
    repeat (3) step();
    base = ns0;
    start0 = 1'b1;
    step();
    wait_done(1'b0, 40, cyc);
    check_eq("t5_latency", cyc, 16);
    check_eq("t5_nsamp", ns0 - base, 8);
    check_sweep("t5", base);
    step();
    check_eq("t5_relaunch", {busy0, done0}, 2'b10);
    check_eq("t5_relaunch_vec", dut_in0, exp_vec[0]);
    wait_done(1'b0, 40, cyc);
    check_eq("t5_latency2", cyc, 16);
    check_eq("t5_sig2", sig0, exp_sig);
    start0 = 1'b0;
    repeat (2) step();
    check_eq("t5_idle", busy0, 0);

    // HOLD=0 instance
    base = ns1;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    check_eq("t6_vec0", dut_in1, exp_vec[0]);
    wait_done(1'b1, 40, cyc);
    check_eq("t6_latency", cyc, 8);
    check_eq("t6_sig", sig1, exp_sig);
    check_eq("t6_nsamp", ns1 - base, 8);
    for (int i = 0; i < 8; i++) begin
      check_eq("t6_dat", 32'(s_dat1[(base + i) % 256]), 32'(exp_dat[i]));
    end
    check_eq("t6_ndone", nd1, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
